// File: rtl/timebase_pkg.sv
// Shared types and constants for the ultrasonic-path timebase counter bank.
// Channel roles: echo width, trigger pulse length, measurement cycle period.
package timebase_pkg;

  typedef enum logic {
    TB_FREE     = 1'b0,
    TB_PERIODIC = 1'b1
  } tb_mode_e;

  localparam int TB_DEFAULT_WIDTH  = 24;
  localparam int TB_DEFAULT_NUM_CH = 3;

  localparam int TB_CH_ECHO  = 0;
  localparam int TB_CH_TRIG  = 1;
  localparam int TB_CH_CYCLE = 2;

  // Low bit index of channel ch inside a flattened NUM_CH*WIDTH bus.
  function automatic int tb_slice_lo(input int ch, input int width);
    return ch * width;
  endfunction

endpackage

// File: rtl/timebase_channel.sv
// One timebase channel: up-counter, terminal compare, registered tc pulse and
// a capture register loaded on the enable falling edge. Build option: TIMEBASE_SATURATE_EN.
module timebase_channel
  import timebase_pkg::*;
#(
  parameter int WIDTH = TB_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             en,
  input  logic             mode,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             tc_pulse,
  output logic [WIDTH-1:0] capture,
  output logic             capture_valid
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_count;
  logic             r_tc_pulse;
  logic [WIDTH-1:0] r_capture;
  logic             r_capture_valid;
  logic             r_en_q;

  logic             w_periodic;
  logic             w_hit;
  logic             w_en_fall;
  logic [WIDTH-1:0] w_count_nxt;
  logic             w_tc_nxt;

  assign w_periodic = (tb_mode_e'(mode) == TB_PERIODIC);
  assign w_hit      = en && (r_count == limit);
  assign w_en_fall  = r_en_q && !en;

  // clear wins over counting and also suppresses the terminal pulse.
  assign w_tc_nxt   = w_hit && !clear;

  always_comb begin
    w_count_nxt = r_count;
    if (clear) begin
      w_count_nxt = '0;
    end else if (en) begin
      if (w_hit && w_periodic) begin
        w_count_nxt = '0;
      end else if (r_count == CNT_MAX) begin
`ifdef TIMEBASE_SATURATE_EN
        w_count_nxt = CNT_MAX;
`else
        w_count_nxt = '0;
`endif
      end else begin
        w_count_nxt = r_count + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count    <= '0;
      r_tc_pulse <= 1'b0;
      r_en_q     <= 1'b0;
    end else begin
      r_count    <= w_count_nxt;
      r_tc_pulse <= w_tc_nxt;
      r_en_q     <= en;
    end
  end

  // Capture samples the pre-clear count; clear never touches this path.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_capture       <= '0;
      r_capture_valid <= 1'b0;
    end else begin
      r_capture_valid <= w_en_fall;
      if (w_en_fall) begin
        r_capture <= r_count;
      end
    end
  end

  assign count         = r_count;
  assign tc_pulse      = r_tc_pulse;
  assign capture       = r_capture;
  assign capture_valid = r_capture_valid;

endmodule

// File: rtl/timebase_bank.sv
// Bank of NUM_CH independent timebase channels; this level only slices the
// flattened buses. Build option: TIMEBASE_SATURATE_EN (see timebase_channel).
module timebase_bank
  import timebase_pkg::*;
#(
  parameter int NUM_CH = TB_DEFAULT_NUM_CH,
  parameter int WIDTH  = TB_DEFAULT_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_CH-1:0]       clear,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH-1:0]       mode,
  input  logic [NUM_CH*WIDTH-1:0] limit,
  output logic [NUM_CH*WIDTH-1:0] count,
  output logic [NUM_CH-1:0]       tc_pulse,
  output logic [NUM_CH*WIDTH-1:0] capture,
  output logic [NUM_CH-1:0]       capture_valid
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    localparam int LO = tb_slice_lo(g, WIDTH);

    timebase_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk          (clk),
      .reset_n      (reset_n),
      .clear        (clear[g]),
      .en           (en[g]),
      .mode         (mode[g]),
      .limit        (limit[LO +: WIDTH]),
      .count        (count[LO +: WIDTH]),
      .tc_pulse     (tc_pulse[g]),
      .capture      (capture[LO +: WIDTH]),
      .capture_valid(capture_valid[g])
    );
  end

endmodule

// File: tb/tb_timebase_bank.sv
// Directed bench for timebase_bank: a 3x24-bit bank plus a 1x4-bit bank for
// the wrap / saturate boundary. Expected values are hand-derived constants.
module tb_timebase_bank;
  import timebase_pkg::*;

  localparam int W  = 24;
  localparam int NC = 3;
  localparam int W4 = 4;

  logic            clk;
  logic            reset_n;
  logic [NC-1:0]   clear;
  logic [NC-1:0]   en;
  logic [NC-1:0]   mode;
  logic [NC*W-1:0] limit;
  logic [NC*W-1:0] count;
  logic [NC-1:0]   tc_pulse;
  logic [NC*W-1:0] capture;
  logic [NC-1:0]   capture_valid;

  logic [0:0]      clear4;
  logic [0:0]      en4;
  logic [0:0]      mode4;
  logic [W4-1:0]   limit4;
  logic [W4-1:0]   count4;
  logic [0:0]      tc4;
  logic [W4-1:0]   capture4;
  logic [0:0]      cv4;

  int n_checks;
  int n_fail;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  timebase_bank #(.NUM_CH(NC), .WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .en(en), .mode(mode),
    .limit(limit), .count(count), .tc_pulse(tc_pulse), .capture(capture),
    .capture_valid(capture_valid)
  );

  timebase_bank #(.NUM_CH(1), .WIDTH(W4)) dut4 (
    .clk(clk), .reset_n(reset_n), .clear(clear4), .en(en4), .mode(mode4),
    .limit(limit4), .count(count4), .tc_pulse(tc4), .capture(capture4),
    .capture_valid(cv4)
  );

  function automatic logic [31:0] cnt(input int ch);
    return 32'(count[ch*W +: W]);
  endfunction

  function automatic logic [31:0] cap(input int ch);
    return 32'(capture[ch*W +: W]);
  endfunction

  // driver tasks
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_limit(input int ch, input int val);
    limit[ch*W +: W] = W'(val);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    clear    = '0;
    en       = '0;
    mode     = '0;
    limit    = '0;
    clear4   = '0;
    en4      = '0;
    mode4    = '0;
    limit4   = '0;
    set_limit(TB_CH_ECHO, 1000);

    // reset for two cycles
    step(2);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_count_hi", 32'(count[NC*W-1:32]), 32'd0);
    chk("reset_tc", 32'(tc_pulse), 32'd0);
    chk("reset_capture", 32'(capture), 32'd0);
    chk("reset_cv", 32'(capture_valid), 32'd0);
    reset_n = 1'b1;

    // enable ch0 for five cycles, then drop and capture
    en[TB_CH_ECHO] = 1'b1;
    step(5);
    chk("ch0_count5", cnt(TB_CH_ECHO), 32'd5);
    en[TB_CH_ECHO] = 1'b0;
    step();
    chk("ch0_capture", cap(TB_CH_ECHO), 32'd5);
    chk("ch0_cv_pulse", 32'(capture_valid), 32'b001);
    chk("ch0_count_hold", cnt(TB_CH_ECHO), 32'd5);
    step();
    chk("ch0_cv_once", 32'(capture_valid), 32'd0);

    // ch1 periodic, limit 3: count 1,2,3,0,... with tc after each 3
    mode[TB_CH_TRIG] = 1'b1;
    set_limit(TB_CH_TRIG, 3);
    en[TB_CH_TRIG] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("ch1_periodic_count_%0d", k), cnt(TB_CH_TRIG), 32'(k % 4));
      chk($sformatf("ch1_periodic_tc_%0d", k), 32'(tc_pulse[TB_CH_TRIG]), 32'((k % 4) == 0));
    end
    en[TB_CH_TRIG] = 1'b0;
    step();

    // ch2 free-run, limit 4: single tc after count leaves 4
    set_limit(TB_CH_CYCLE, 4);
    en[TB_CH_CYCLE] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      chk($sformatf("ch2_free_count_%0d", k), cnt(TB_CH_CYCLE), 32'(k));
      chk($sformatf("ch2_free_tc_%0d", k), 32'(tc_pulse[TB_CH_CYCLE]), 32'(k == 5));
    end
    clear[TB_CH_CYCLE] = 1'b1;
    step();
    chk("ch2_clear_count", cnt(TB_CH_CYCLE), 32'd0);
    chk("ch2_clear_tc", 32'(tc_pulse[TB_CH_CYCLE]), 32'd0);
    clear[TB_CH_CYCLE] = 1'b0;

    // en fall and clear together at count 10 (limit raised so no tc)
    set_limit(TB_CH_CYCLE, 500);
    step(10);
    chk("ch2_count10", cnt(TB_CH_CYCLE), 32'd10);
    en[TB_CH_CYCLE]    = 1'b0;
    clear[TB_CH_CYCLE] = 1'b1;
    step();
    chk("ch2_fall_clear_capture", cap(TB_CH_CYCLE), 32'd10);
    chk("ch2_fall_clear_cv", 32'(capture_valid), 32'b100);
    chk("ch2_fall_clear_count", cnt(TB_CH_CYCLE), 32'd0);
    clear[TB_CH_CYCLE] = 1'b0;

    // clear while ch1 sits on its limit with en=1: no tc
    en[TB_CH_TRIG] = 1'b1;
    step(3);
    chk("ch1_at_limit", cnt(TB_CH_TRIG), 32'd3);
    clear[TB_CH_TRIG] = 1'b1;
    step();
    chk("ch1_clear_at_limit_count", cnt(TB_CH_TRIG), 32'd0);
    chk("ch1_clear_at_limit_tc", 32'(tc_pulse[TB_CH_TRIG]), 32'd0);
    clear[TB_CH_TRIG] = 1'b0;
    en[TB_CH_TRIG]    = 1'b0;
    step();

    // ch1 periodic with limit 0: count stays 0, tc every enabled cycle
    set_limit(TB_CH_TRIG, 0);
    en[TB_CH_TRIG] = 1'b1;
    step();
    chk("ch1_lim0_count_a", cnt(TB_CH_TRIG), 32'd0);
    chk("ch1_lim0_tc_a", 32'(tc_pulse[TB_CH_TRIG]), 32'd1);
    step();
    chk("ch1_lim0_count_b", cnt(TB_CH_TRIG), 32'd0);
    chk("ch1_lim0_tc_b", 32'(tc_pulse[TB_CH_TRIG]), 32'd1);
    en[TB_CH_TRIG] = 1'b0;
    step(2);

    // reset while ch0 counts at 7 with en=1
    clear[TB_CH_ECHO] = 1'b1;
    step();
    clear[TB_CH_ECHO] = 1'b0;
    en[TB_CH_ECHO]    = 1'b1;
    step(7);
    chk("ch0_count7", cnt(TB_CH_ECHO), 32'd7);
    reset_n = 1'b0;
    step();
    chk("midreset_count", 32'(count[31:0]), 32'd0);
    chk("midreset_count_hi", 32'(count[NC*W-1:32]), 32'd0);
    chk("midreset_capture", 32'(capture[31:0]), 32'd0);
    chk("midreset_capture_hi", 32'(capture[NC*W-1:32]), 32'd0);
    chk("midreset_tc", 32'(tc_pulse), 32'd0);
    en[TB_CH_ECHO] = 1'b0;
    reset_n = 1'b1;
    step();
    chk("release_cv", 32'(capture_valid), 32'd0);
    chk("release_capture0", cap(TB_CH_ECHO), 32'd0);
    chk("release_count0", cnt(TB_CH_ECHO), 32'd0);

    // 4-bit channel, free-run, limit 15, from 0
    limit4 = 4'd15;
    en4    = 1'b1;
    step(15);
    chk("w4_count15", 32'(count4), 32'd15);
    chk("w4_tc_before", 32'(tc4), 32'd0);
    step();
`ifdef TIMEBASE_SATURATE_EN
    chk("w4_sat_count_a", 32'(count4), 32'd15);
    chk("w4_sat_tc_a", 32'(tc4), 32'd1);
    step();
    chk("w4_sat_count_b", 32'(count4), 32'd15);
    chk("w4_sat_tc_b", 32'(tc4), 32'd1);
`else
    chk("w4_wrap_count_a", 32'(count4), 32'd0);
    chk("w4_wrap_tc_a", 32'(tc4), 32'd1);
    step();
    chk("w4_wrap_count_b", 32'(count4), 32'd1);
    chk("w4_wrap_tc_b", 32'(tc4), 32'd0);
`endif
    en4 = 1'b0;
    step();
    chk("w4_cv", 32'(cv4), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/timebase_bank.md
Name: timebase_bank

Overview:
- Parametrised bank of NUM_CH independent up-counters for the ultrasonic sensor path: echo width, trigger pulse length and measurement cycle period.
- Each channel has:
  - clear and enable inputs
  - free-run or periodic (auto-reload) mode
  - a programmable terminal value with a registered terminal-count pulse
  - a capture register latched on the enable falling edge
- Feeds the sensor controller FSM, which no longer compares raw counts itself.

Parameters:
- NUM_CH, 3, number of independent counter channels (ch0 echo, ch1 trigger, ch2 cycle by convention).
- WIDTH, 24, counter, limit and capture width in bits, legal range 2..32.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  synchronous active-low reset.
- clear  in  NUM_CH  per-channel synchronous counter clear.
- en  in  NUM_CH  per-channel count enable.
- mode  in  NUM_CH  per-channel mode: 0 = free-run, 1 = periodic reload.
- limit  in  NUM_CH*WIDTH  per-channel terminal value, channel i at [i*WIDTH +: WIDTH].
- count  out  NUM_CH*WIDTH  per-channel current count, registered.
- tc_pulse  out  NUM_CH  one-cycle terminal-count pulse, registered.
- capture  out  NUM_CH*WIDTH  count value latched at the en falling edge.
- capture_valid  out  NUM_CH  one-cycle pulse, coincident with a capture update.

Behaviour:
- Reset:
  - reset_n = 0 at a clk edge forces count, tc_pulse, capture, capture_valid and the internal en_q to 0.
  - Reset mid-count discards all state; no capture is produced.
- Priority per channel: reset_n > clear > en.
- Counting: en = 1 and clear = 0 -> count <= count + 1 on the next edge. en = 0 -> count holds.
- Terminal hit: en = 1 and count == limit.
  - tc_pulse = 1 in the following cycle.
  - Periodic mode: count <= 0 instead of incrementing.
  - Free-run mode: count increments normally; tc fires once per pass.
- limit = 0 in periodic mode: count stays 0; tc_pulse asserts every enabled cycle.
- Wrap: count == 2^WIDTH-1 with en = 1 and no terminal hit -> count <= 0 (default build).
- Capture:
  - en_q holds en delayed one cycle.
  - en_q = 1 and en = 0 -> capture <= count and capture_valid = 1 for one cycle.
  - capture takes the pre-clear value even if clear is asserted in the same cycle.
- clear:
  - clear with en = 1 -> count <= 0, no increment, no tc_pulse that cycle.
  - clear does not affect capture or en_q.
- Mode or limit change applies from the next edge's comparison; no pulse is generated by the change itself.
- Channels are fully independent; no shared state between them.
- Latency: en to first count change is 1 cycle; terminal hit to tc_pulse is 1 cycle; en fall to capture_valid is 1 cycle.

Optional Feature:
- Macro: TIMEBASE_SATURATE_EN.
- Defined:
  - count holds at 2^WIDTH-1 instead of wrapping.
  - A held count does not retrigger tc_pulse unless limit == 2^WIDTH-1, in which case tc_pulse stays asserted while en = 1 in free-run mode.
  - Periodic reload still takes precedence over saturation.
- Undefined: wrap-to-0 as specified under Behaviour.

Decomposition:
- Package timebase_pkg:
  - tb_mode_e enum (TB_FREE = 1'b0, TB_PERIODIC = 1'b1)
  - constants TB_DEFAULT_WIDTH = 24, TB_DEFAULT_NUM_CH = 3
  - channel index constants TB_CH_ECHO = 0, TB_CH_TRIG = 1, TB_CH_CYCLE = 2
- Sub-module timebase_channel (WIDTH parameter):
  - one counter, en_q, terminal compare, capture logic
  - instantiated NUM_CH times in a generate loop
  - top level handles only bus slicing

Test Plan:
- Reset and enable:
  - reset_n = 0 for 2 cycles, then en[0] = 1 for 5 cycles -> count ch0 = 5.
  - en[0] drops -> capture ch0 = 5, capture_valid[0] pulses once.
- Periodic mode:
  - ch1 mode = 1, limit = 3, en held -> count sequence 0,1,2,3,0,1,…
  - tc_pulse[1] high one cycle after each count == 3, i.e. every 4 cycles.
- Free-run terminal:
  - ch2 mode = 0, limit = 4 -> single tc_pulse, count continues 5,6,…
  - clear -> count = 0 on the next edge.
- Simultaneous events:
  - en falling edge and clear in the same cycle at count 10 -> capture = 10, count = 0.
  - clear with en = 1 at count == limit -> no tc_pulse.
- Boundary, WIDTH = 4, limit = 15, free-run, count from 0:
  - default build: tc_pulse after count 15, count wraps 15 -> 0.
  - with TIMEBASE_SATURATE_EN: count holds at 15 and tc_pulse stays high while en = 1.
- Reset mid-operation: reset_n = 0 while ch0 counting at 7 and en = 1 -> all outputs 0, no capture_valid on release.
